// File: rtl/axi4_lite_cmd_master_if.sv
// AXI4-Lite channel bundle between a register-access master and its slave.
// Master drives AW/W/AR and the B/R ready strobes; the slave drives everything else.
interface axi4_lite_cmd_master_if #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6
);
    logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]                      M_AXI_AWPROT;
    logic                            M_AXI_AWVALID;
    logic                            M_AXI_AWREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                            M_AXI_WVALID;
    logic                            M_AXI_WREADY;
    logic [1:0]                      M_AXI_BRESP;
    logic                            M_AXI_BVALID;
    logic                            M_AXI_BREADY;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]                      M_AXI_ARPROT;
    logic                            M_AXI_ARVALID;
    logic                            M_AXI_ARREADY;
    logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]                      M_AXI_RRESP;
    logic                            M_AXI_RVALID;
    logic                            M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi4_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: one command in, one AXI transaction, one response out.
// Response 3 cycles after accept with zero-wait slave; rsp_ready low stalls only the RSP state.
module axi4_lite_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 6,
    parameter int CNT_WIDTH          = 16
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    axi4_lite_cmd_master_if.master          m_axi,
    output logic [CNT_WIDTH-1:0]            wr_count,
    output logic [CNT_WIDTH-1:0]            rd_count,
    output logic [CNT_WIDTH-1:0]            err_count
);
    typedef enum logic [2:0] {IDLE, WR, WAIT_B, RD, WAIT_R, RSP} state_t;

    state_t state;
    logic   aw_done;
    logic   w_done;
    logic   aw_done_nxt;
    logic   w_done_nxt;

    assign m_axi.M_AXI_AWPROT = 3'b000;
    assign m_axi.M_AXI_ARPROT = 3'b000;

    // A channel counts as done once it has handshaken, including in the current cycle.
    assign aw_done_nxt = aw_done | (m_axi.M_AXI_AWVALID & m_axi.M_AXI_AWREADY);
    assign w_done_nxt  = w_done  | (m_axi.M_AXI_WVALID  & m_axi.M_AXI_WREADY);

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state                <= IDLE;
            cmd_ready            <= 1'b1;
            aw_done              <= 1'b0;
            w_done               <= 1'b0;
            m_axi.M_AXI_AWADDR   <= '0;
            m_axi.M_AXI_AWVALID  <= 1'b0;
            m_axi.M_AXI_WDATA    <= '0;
            m_axi.M_AXI_WSTRB    <= '0;
            m_axi.M_AXI_WVALID   <= 1'b0;
            m_axi.M_AXI_BREADY   <= 1'b0;
            m_axi.M_AXI_ARADDR   <= '0;
            m_axi.M_AXI_ARVALID  <= 1'b0;
            m_axi.M_AXI_RREADY   <= 1'b0;
            rsp_valid            <= 1'b0;
            rsp_write            <= 1'b0;
            rsp_rdata            <= '0;
            rsp_resp             <= 2'b00;
            wr_count             <= '0;
            rd_count             <= '0;
            err_count            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            m_axi.M_AXI_AWADDR  <= cmd_addr;
                            m_axi.M_AXI_WDATA   <= cmd_wdata;
                            m_axi.M_AXI_WSTRB   <= cmd_wstrb;
                            m_axi.M_AXI_AWVALID <= 1'b1;
                            m_axi.M_AXI_WVALID  <= 1'b1;
                            m_axi.M_AXI_BREADY  <= 1'b1;
                            aw_done             <= 1'b0;
                            w_done              <= 1'b0;
                            state               <= WR;
                        end else begin
                            m_axi.M_AXI_ARADDR  <= cmd_addr;
                            m_axi.M_AXI_ARVALID <= 1'b1;
                            state               <= RD;
                        end
                    end
                end
                WR: begin
                    if (m_axi.M_AXI_AWREADY) m_axi.M_AXI_AWVALID <= 1'b0;
                    if (m_axi.M_AXI_WREADY)  m_axi.M_AXI_WVALID  <= 1'b0;
                    aw_done <= aw_done_nxt;
                    w_done  <= w_done_nxt;
                    if (aw_done_nxt && w_done_nxt) state <= WAIT_B;
                end
                WAIT_B: begin
                    if (m_axi.M_AXI_BVALID) begin
                        m_axi.M_AXI_BREADY <= 1'b0;
                        rsp_valid          <= 1'b1;
                        rsp_write          <= 1'b1;
                        rsp_rdata          <= '0;
                        rsp_resp           <= m_axi.M_AXI_BRESP;
                        wr_count           <= sat_inc(wr_count);
                        if (m_axi.M_AXI_BRESP != 2'b00) err_count <= sat_inc(err_count);
                        state              <= RSP;
                    end
                end
                RD: begin
                    if (m_axi.M_AXI_ARREADY) begin
                        m_axi.M_AXI_ARVALID <= 1'b0;
                        m_axi.M_AXI_RREADY  <= 1'b1;
                        state               <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (m_axi.M_AXI_RVALID) begin
                        m_axi.M_AXI_RREADY <= 1'b0;
                        rsp_valid          <= 1'b1;
                        rsp_write          <= 1'b0;
                        rsp_rdata          <= m_axi.M_AXI_RDATA;
                        rsp_resp           <= m_axi.M_AXI_RRESP;
                        rd_count           <= sat_inc(rd_count);
                        if (m_axi.M_AXI_RRESP != 2'b00) err_count <= sat_inc(err_count);
                        state              <= RSP;
                    end
                end
                RSP: begin
                    // Re-arming cmd_ready here lets the next command land the cycle after the handshake.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi4_lite_cmd_master.md
# axi4_lite_cmd_master

Command-driven AXI4-Lite master that turns single register-access requests (from a host bridge or control sequencer) into AXI4-Lite read or write transactions. It sits directly upstream of the AXI4-Lite register-file slaves (axi4_lite_slave) and drives their S_AXI port. It returns each transaction's response on a valid/ready response port and keeps saturating transaction and error counters.

## Interface
- C_M_AXI_DATA_WIDTH, 32, AXI data width; also the width of cmd_wdata and rsp_rdata.
- C_M_AXI_ADDR_WIDTH, 6, AXI address width; also the width of cmd_addr.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESETN  in  1  synchronous, active-low reset.
- cmd_valid, cmd_ready  in/out  1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address, forwarded unchanged.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes.
- rsp_valid, rsp_ready  out/in  1  response handshake.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, M_AXI_WDATA/WSTRB/WVALID/WREADY, M_AXI_BRESP/BVALID/BREADY, M_AXI_ARADDR/ARPROT/ARVALID/ARREADY, M_AXI_RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master channels. All signal widths follow the parameters.
- wr_count, rd_count, err_count  out  CNT_WIDTH  completed writes, completed reads, and responses with resp != 2'b00.

## Operation
- FSM states:
  - IDLE
  - WR (AW and/or W outstanding)
  - WAIT_B
  - RD (AR outstanding)
  - WAIT_R
  - RSP
- IDLE:
  - cmd_ready = 1 only in IDLE and only when rsp_valid = 0.
  - On cmd_valid && cmd_ready, latch all cmd_* fields.
  - Go to WR if cmd_write = 1, else to RD.
- WR:
  - AWVALID and WVALID are registered and rise together in the cycle after acceptance.
  - Each channel drops independently in the cycle after its own handshake; aw_done and w_done flags track completion.
  - When both flags are set, go to WAIT_B.
  - AW and W may complete in either order or in the same cycle.
- BREADY = 1 in WR and WAIT_B. A B handshake can only occur after both AW and W complete. On the B handshake, capture BRESP and go to RSP.
- RD:
  - ARVALID rises in the cycle after acceptance and holds until ARREADY.
  - Then go to WAIT_R with RREADY = 1.
  - On the R handshake, capture RDATA and RRESP and go to RSP.
- RSP:
  - rsp_valid = 1 with stable rsp_* fields until rsp_ready.
  - Then go to IDLE. A new command can be accepted in the cycle after the rsp handshake.
- AWPROT = ARPROT = 3'b000. Exactly one transaction is outstanding at any time.
- Counters:
  - wr_count and rd_count increment in the cycle of the B/R handshake.
  - err_count increments on the same handshake when resp != 2'b00.
  - All counters saturate at all-ones and never wrap.
- AXI VALID signals never deassert before their handshake. AXI address and data outputs stay stable while VALID is high.

## Timing
- Reset (synchronous, M_AXI_ARESETN = 0 at a clock edge) drives:
  - state = IDLE
  - all VALID outputs and BREADY/RREADY = 0
  - rsp_valid = 0, rsp_resp = 0, rsp_rdata = 0, rsp_write = 0
  - all counters = 0
  - cmd_ready = 1 from the first cycle after reset release
  - AWADDR/ARADDR/WDATA/WSTRB = 0
- Reset mid-transaction abandons the transaction at once. No response is produced.
- Write latency with zero-wait AWREADY/WREADY and BVALID one cycle after AW/W:
  - accept at cycle 0
  - AW/W handshake at cycle 1
  - B handshake at cycle 2
  - rsp_valid at cycle 3
- Read latency with zero-wait ARREADY and RVALID one cycle later:
  - accept at cycle 0
  - AR handshake at cycle 1
  - R handshake at cycle 2
  - rsp_valid at cycle 3
- Against axi4_lite_slave (AWREADY/WREADY asserted one cycle after both valids are seen):
  - write: rsp_valid at cycle 4
  - read: rsp_valid at cycle 4
- Back-pressure on rsp_ready stalls only the RSP state. Counters already reflect the transaction.

## Test plan
- Write then read-back: write addr 0x08, data 0xDEADBEEF, strb 4'hF to axi4_lite_slave; then read 0x08.
  - Required: write rsp_resp = 0, rsp_rdata = 0.
  - Required: read rsp_rdata = 0xDEADBEEF.
  - Required: wr_count = 1, rd_count = 1, err_count = 0.
- Partial strobe: preload 0x11223344 at 0x04; write 0xAABBCCDD with strb 4'b0101; read back.
  - Required: read returns 0x11BB33DD.
- Skewed channels: an AXI responder model asserts WREADY 3 cycles before AWREADY.
  - Required: WVALID drops after its own handshake, AWVALID holds, exactly one B is accepted, one response is produced.
- Error and saturation: responder returns RRESP = 2'b10 with CNT_WIDTH = 2, for 5 reads.
  - Required: every rsp_resp = 2'b10.
  - Required: err_count and rd_count stick at 3.
- Back-pressure: hold rsp_ready = 0 for 10 cycles with cmd_valid high.
  - Required: cmd_ready = 0 throughout, rsp fields stable.
  - Required: next command accepted the cycle after the rsp handshake.
- Reset mid-write: deassert M_AXI_ARESETN while AWVALID = 1.
  - Required: all valids, rsp_valid and counters are 0 the next cycle; cmd_ready = 1 after release.
